// File: rtl/dual_port_ram.sv
// Two-write, two-read single-clock RAM with registered read data.
// Optional write-to-read bypass: define DUAL_PORT_RAM_WR_BYPASS_EN for write-first reads.
module dual_port_ram #(
    parameter int width = 8,
    parameter int depth = 256,
    parameter int addr  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en0,
    input  logic             rd_en1,
    input  logic             wr_en0,
    input  logic             wr_en1,
    input  logic [width-1:0] data_in0,
    input  logic [width-1:0] data_in1,
    input  logic [addr-1:0]  rd_addr0,
    input  logic [addr-1:0]  wr_addr0,
    input  logic [addr-1:0]  rd_addr1,
    input  logic [addr-1:0]  wr_addr1,
    output logic [width-1:0] data_out0,
    output logic [width-1:0] data_out1
);

    logic [width-1:0] r_mem [0:depth-1];
    logic [width-1:0] r_data_out0;
    logic [width-1:0] r_data_out1;
    logic [width-1:0] w_rd_data0;
    logic [width-1:0] w_rd_data1;
    logic             w_wr1_allowed;

    // Port 0 owns a shared write address, so port 1 is dropped on a collision.
    assign w_wr1_allowed = wr_en1 && !(wr_en0 && (wr_addr0 == wr_addr1));

`ifdef DUAL_PORT_RAM_WR_BYPASS_EN
    always_comb begin
        w_rd_data0 = r_mem[rd_addr0];
        if (wr_en0 && (wr_addr0 == rd_addr0)) begin
            w_rd_data0 = data_in0;
        end else if (wr_en1 && (wr_addr1 == rd_addr0)) begin
            w_rd_data0 = data_in1;
        end
    end

    always_comb begin
        w_rd_data1 = r_mem[rd_addr1];
        if (wr_en0 && (wr_addr0 == rd_addr1)) begin
            w_rd_data1 = data_in0;
        end else if (wr_en1 && (wr_addr1 == rd_addr1)) begin
            w_rd_data1 = data_in1;
        end
    end
`else
    assign w_rd_data0 = r_mem[rd_addr0];
    assign w_rd_data1 = r_mem[rd_addr1];
`endif

    // Reset only blocks writes; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_en0) begin
                r_mem[wr_addr0] <= data_in0;
            end
            if (w_wr1_allowed) begin
                r_mem[wr_addr1] <= data_in1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out0 <= '0;
            r_data_out1 <= '0;
        end else begin
            if (rd_en0) begin
                r_data_out0 <= w_rd_data0;
            end
            if (rd_en1) begin
                r_data_out1 <= w_rd_data1;
            end
        end
    end

    assign data_out0 = r_data_out0;
    assign data_out1 = r_data_out1;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: directed scenarios with literal expectations,
// then random traffic checked every cycle against an array-based reference model.
module tb_dual_port_ram;

    logic       clk;
    logic       rst;
    logic       rd_en0;
    logic       rd_en1;
    logic       wr_en0;
    logic       wr_en1;
    logic [7:0] data_in0;
    logic [7:0] data_in1;
    logic [7:0] rd_addr0;
    logic [7:0] wr_addr0;
    logic [7:0] rd_addr1;
    logic [7:0] wr_addr1;
    logic [7:0] data_out0;
    logic [7:0] data_out1;

    int total;
    int bad;
    bit checkEn;

    // Reference model: plain array plus per-location "has been written" flags.
    logic [7:0] mMem [0:255];
    bit         mWritten [0:255];
    logic [7:0] mOut0;
    logic [7:0] mOut1;
    bit         mValid0;
    bit         mValid1;

    dual_port_ram #(.width(8), .depth(256), .addr(8)) dut (
        .clk(clk),
        .rst(rst),
        .rd_en0(rd_en0),
        .rd_en1(rd_en1),
        .wr_en0(wr_en0),
        .wr_en1(wr_en1),
        .data_in0(data_in0),
        .data_in1(data_in1),
        .rd_addr0(rd_addr0),
        .wr_addr0(wr_addr0),
        .rd_addr1(rd_addr1),
        .wr_addr1(wr_addr1),
        .data_out0(data_out0),
        .data_out1(data_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, actual, expected);
        end
    endtask

    // What a read of address a returns this cycle, from the current model contents.
    function automatic void modelRead(input logic [7:0] a, output logic [7:0] v, output bit ok);
        v  = mMem[a];
        ok = mWritten[a];
`ifdef DUAL_PORT_RAM_WR_BYPASS_EN
        if (wr_en0 && wr_addr0 == a) begin
            v  = data_in0;
            ok = 1'b1;
        end else if (wr_en1 && wr_addr1 == a) begin
            v  = data_in1;
            ok = 1'b1;
        end
`endif
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mWritten[i] = 1'b0;
        mValid0 = 1'b0;
        mValid1 = 1'b0;
        mOut0   = '0;
        mOut1   = '0;
    end

    always @(posedge clk) begin
        logic [7:0] v;
        bit         ok;
        if (rst) begin
            mOut0   <= 8'h00;
            mOut1   <= 8'h00;
            mValid0 <= 1'b1;
            mValid1 <= 1'b1;
        end else begin
            if (rd_en0) begin
                modelRead(rd_addr0, v, ok);
                mOut0   <= v;
                mValid0 <= ok;
            end
            if (rd_en1) begin
                modelRead(rd_addr1, v, ok);
                mOut1   <= v;
                mValid1 <= ok;
            end
            if (wr_en1) begin
                mMem[wr_addr1]     <= data_in1;
                mWritten[wr_addr1] <= 1'b1;
            end
            if (wr_en0) begin
                mMem[wr_addr0]     <= data_in0;
                mWritten[wr_addr0] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            if (mValid0) checkOutput("model_out0", data_out0, mOut0);
            if (mValid1) checkOutput("model_out1", data_out1, mOut1);
        end
    end

    task automatic applyStimulus(input logic r, input logic re0, input logic [7:0] ra0,
                                 input logic re1, input logic [7:0] ra1,
                                 input logic we0, input logic [7:0] wa0, input logic [7:0] d0,
                                 input logic we1, input logic [7:0] wa1, input logic [7:0] d1);
        rst      = r;
        rd_en0   = re0;
        rd_addr0 = ra0;
        rd_en1   = re1;
        rd_addr1 = ra1;
        wr_en0   = we0;
        wr_addr0 = wa0;
        data_in0 = d0;
        wr_en1   = we1;
        wr_addr1 = wa1;
        data_in1 = d1;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    endtask

    initial begin
        logic [7:0] expRdw;
        total   = 0;
        bad     = 0;
        checkEn = 1'b0;
        @(negedge clk);

        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        checkEn = 1'b1;
        checkOutput("rst1_out0", data_out0, 8'h00);
        checkOutput("rst1_out1", data_out1, 8'h00);
        idle();
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        checkOutput("rst2_out0", data_out0, 8'h00);
        checkOutput("rst2_out1", data_out1, 8'h00);

        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 8'h0A, 8'h55, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h0B, 8'hAA);
        applyStimulus(0, 1, 8'h0A, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 8'h00, 1, 8'h0B, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        repeat (3) idle();
        checkOutput("hold_out0", data_out0, 8'h55);
        checkOutput("hold_out1", data_out1, 8'hAA);
        checkOutput("model_hold0", mOut0, 8'h55);

        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'hFF, 8'h3C);
        applyStimulus(0, 1, 8'hFF, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        checkOutput("cross_ff", data_out0, 8'h3C);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        checkOutput("cross_00", data_out1, 8'h00);

        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 8'h10, 8'h11, 1, 8'h10, 8'h22);
        applyStimulus(0, 1, 8'h10, 1, 8'h10, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        checkOutput("collide_out0", data_out0, 8'h11);
        checkOutput("collide_out1", data_out1, 8'h11);
        checkOutput("model_collide", mOut1, 8'h11);

        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 8'h20, 8'h01, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 8'h00, 1, 8'h20, 1, 8'h20, 8'h02, 0, 8'h00, 8'h00);
`ifdef DUAL_PORT_RAM_WR_BYPASS_EN
        expRdw = 8'h02;
`else
        expRdw = 8'h01;
`endif
        checkOutput("rdw_out1", data_out1, expRdw);
        checkOutput("model_rdw", mOut1, expRdw);
        applyStimulus(0, 0, 8'h00, 1, 8'h20, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        checkOutput("rdw_after", data_out1, 8'h02);

        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 8'h30, 8'h66, 0, 8'h00, 8'h00);
        applyStimulus(1, 1, 8'h30, 0, 8'h00, 1, 8'h30, 8'h77, 0, 8'h00, 8'h00);
        checkOutput("rstwr_out0", data_out0, 8'h00);
        applyStimulus(0, 1, 8'h30, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        checkOutput("rstwr_keep", data_out0, 8'h66);

        // Narrow address window so collisions and read-during-write happen often.
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          1'($urandom), 8'($urandom_range(0, 15)),
                          1'($urandom), 8'($urandom_range(0, 15)),
                          1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                          1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 Parameter width, default 8: data word width in bits.
REQ-002 Parameter depth, default 256: number of words; SHALL equal 2**addr.
REQ-003 Parameter addr, default 8: address width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rd_en0  input  1  port-0 read enable.
REQ-007 rd_en1  input  1  port-1 read enable.
REQ-008 wr_en0  input  1  port-0 write enable.
REQ-009 wr_en1  input  1  port-1 write enable.
REQ-010 data_in0  input  width  port-0 write data.
REQ-011 data_in1  input  width  port-1 write data.
REQ-012 rd_addr0  input  addr  port-0 read address.
REQ-013 wr_addr0  input  addr  port-0 write address.
REQ-014 rd_addr1  input  addr  port-1 read address.
REQ-015 wr_addr1  input  addr  port-1 write address.
REQ-016 data_out0  output  width  port-0 registered read data.
REQ-017 data_out1  output  width  port-1 registered read data.

Function
REQ-018 Storage SHALL be depth x width words shared by both ports; each port has an independent write path and an independent read path, giving up to 2 writes and 2 reads per cycle.
REQ-019 When wr_enN=1 at a rising edge, mem[wr_addrN] SHALL take data_inN at that edge.
REQ-020 When rd_enN=1 at a rising edge, data_outN SHALL be loaded from mem[rd_addrN], giving 1-cycle read latency.
REQ-021 When rd_enN=0, data_outN SHALL hold its last value indefinitely.
REQ-022 If wr_en0=wr_en1=1 and wr_addr0==wr_addr1, port 0 data SHALL be stored and port 1 data discarded.
REQ-023 Without the bypass macro, a read of an address written in the same cycle SHALL return the pre-write contents (read-first).
REQ-024 Both ports SHALL read the same address simultaneously without conflict and return identical data.
REQ-025 Address ranges SHALL span the full array (0 to depth-1); there is no out-of-range case and no wrap logic.
REQ-026 Contents of never-written locations SHALL be undefined (X in simulation); no initialisation file is used.

Reset
REQ-027 While rst=1 at a rising edge, data_out0 and data_out1 SHALL become 0.
REQ-028 While rst=1, all writes and reads SHALL be suppressed, and memory contents SHALL be retained, not cleared.
REQ-029 Reset asserted mid-operation SHALL take priority over any concurrent rd_en or wr_en in that cycle.
REQ-030 Operation SHALL resume on the first rising edge with rst=0.

Configuration
REQ-031 Macro DUAL_PORT_RAM_WR_BYPASS_EN: when defined, a read whose rd_addrN matches an active write address in the same cycle SHALL return the newly written data (write-first).
REQ-032 With DUAL_PORT_RAM_WR_BYPASS_EN defined and both ports writing the matching address, the bypass SHALL return port 0 data, consistent with REQ-022.
REQ-033 When DUAL_PORT_RAM_WR_BYPASS_EN is undefined, REQ-023 read-first behaviour SHALL apply, with no bypass logic synthesised.

Verification
REQ-034 Reset: pulse rst for one cycle, release, pulse again -> data_out0=data_out1=00 after each pulse.
REQ-035 Write 55 to addr 0A via port 0, then write AA to addr 0B via port 1; read 0A on port 0 for one cycle, then read 0B on port 1 for one cycle; all enables then low -> data_out0=55 and data_out1=AA, both held.
REQ-036 Cross-port access: write 3C to addr FF via port 1, read FF on port 0 the next cycle -> data_out0=3C; write 00 to addr 00 via port 0, read 00 on port 1 -> data_out1=00.
REQ-037 Dual-write collision: wr_en0=wr_en1=1, both to addr 10, data_in0=11, data_in1=22; read 10 on either port later -> 11.
REQ-038 Read-during-write: mem[20]=01; in one cycle write 02 to addr 20 on port 0 and read 20 on port 1 -> data_out1=01 without the macro, 02 with DUAL_PORT_RAM_WR_BYPASS_EN.
REQ-039 Reset during write: rst=1 with wr_en0=1, addr 30, data 77, where mem[30]=66 beforehand; after release, read 30 -> 66, and data_out0 is 00 during reset.
